// File: rtl/aurora_tx_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : aurora_tx_frame_gen
// Purpose  : AXI-Stream frame generator feeding an Aurora TX user interface.
// Revision : 1.0
// ============================================================================
module aurora_tx_frame_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int GAP_CYCLES = 16
) (
  input  logic                    sys_clk_i,
  input  logic                    rst_i,
  input  logic                    start_en_i,
  input  logic                    channel_up,
  input  logic                    s_axi_tx_tready,
  output logic [DATA_WIDTH-1:0]   s_axi_tx_tdata,
  output logic [DATA_WIDTH/8-1:0] s_axi_tx_tkeep,
  output logic                    s_axi_tx_tlast,
  output logic                    s_axi_tx_tvalid,
  output logic [31:0]             frame_cnt_o,
  output logic [15:0]             abort_cnt_o,
  output logic                    busy_o
);

  localparam logic [15:0]             c_LAST     = 16'(FRAME_LEN - 1);
  localparam logic [15:0]             c_GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0]             c_MARK     = 16'hA55A;
  localparam logic [DATA_WIDTH/8-1:0] c_KEEP     = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [15:0]             r_k;
  logic [15:0]             r_seq;
  logic [15:0]             r_gap;
  logic [31:0]             r_frame_cnt;
  logic [15:0]             r_abort_cnt;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [DATA_WIDTH/8-1:0] r_tkeep;

  logic        w_go;
  logic [15:0] w_k_next;
  logic [15:0] w_seq_next;

  assign w_go       = start_en_i && channel_up;
  assign w_k_next   = r_k + 16'd1;
  assign w_seq_next = r_seq + 16'd1;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_seq       <= '0;
      r_gap       <= '0;
      r_frame_cnt <= '0;
      r_abort_cnt <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state  <= SEND;
            r_busy   <= 1'b1;
            r_tvalid <= 1'b1;
            r_tkeep  <= c_KEEP;
            r_tdata  <= {c_MARK, r_seq};
            r_tlast  <= 1'b0;
            r_k      <= '0;
          end
        end
        SEND: begin
          // Loss of channel wins over any beat on the same edge.
          if (!channel_up) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tkeep  <= '0;
            r_tdata  <= '0;
            r_k      <= '0;
            if (r_abort_cnt != 16'hFFFF) r_abort_cnt <= r_abort_cnt + 16'd1;
          end else if (s_axi_tx_tready) begin
            if (r_k == c_LAST) begin
              r_k         <= '0;
              r_seq       <= w_seq_next;
              r_frame_cnt <= r_frame_cnt + 32'd1;
              if (GAP_CYCLES == 0 && w_go) begin
                r_tdata <= {c_MARK, w_seq_next};
                r_tlast <= 1'b0;
              end else begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_tkeep  <= '0;
                r_tdata  <= '0;
                if (GAP_CYCLES > 0) begin
                  r_state <= GAP;
                  r_gap   <= c_GAP_LAST;
                end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end
              end
            end else begin
              r_k     <= w_k_next;
              r_tdata <= {r_seq, w_k_next};
              r_tlast <= (w_k_next == c_LAST);
            end
          end
        end
        GAP: begin
          if (r_gap == 16'd0) begin
            if (w_go) begin
              r_state  <= SEND;
              r_tvalid <= 1'b1;
              r_tkeep  <= c_KEEP;
              r_tdata  <= {c_MARK, r_seq};
              r_tlast  <= 1'b0;
              r_k      <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap <= r_gap - 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_tx_tdata  = r_tdata;
  assign s_axi_tx_tkeep  = r_tkeep;
  assign s_axi_tx_tlast  = r_tlast;
  assign s_axi_tx_tvalid = r_tvalid;
  assign frame_cnt_o     = r_frame_cnt;
  assign abort_cnt_o     = r_abort_cnt;
  assign busy_o          = r_busy;

endmodule
`default_nettype wire

// File: doc/aurora_tx_frame_gen.md
AURORA_TX_FRAME_GEN -- requirements
Module: aurora_tx_frame_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: sys_clk_i is the clock and rst_i is the reset, sampled on the rising edge of sys_clk_i.
REQ-002 Parameter DATA_WIDTH, default 32: AXI-Stream data width in bits; only 32 is supported.
REQ-003 Parameter FRAME_LEN, default 256: words per frame; legal range 2..65535.
REQ-004 Parameter GAP_CYCLES, default 16: idle cycles between frames; legal range 0..65535.
REQ-005 sys_clk_i  input  1: Aurora user_clk.
REQ-006 rst_i  input  1: synchronous active-high reset, driven from Aurora sys_reset_out.
REQ-007 start_en_i  input  1: level enable; while high, the block generates frames continuously.
REQ-008 channel_up  input  1: Aurora channel status; no beat is offered while it is low.
REQ-009 s_axi_tx_tready  input  1: Aurora TX ready.
REQ-010 s_axi_tx_tdata  output  DATA_WIDTH: TX payload word.
REQ-011 s_axi_tx_tkeep  output  DATA_WIDTH/8: byte enables.
REQ-012 s_axi_tx_tlast  output  1: marks the last word of a frame.
REQ-013 s_axi_tx_tvalid  output  1: TX valid.
REQ-014 frame_cnt_o  output  32: count of completed frames.
REQ-015 abort_cnt_o  output  16: count of aborted frames.
REQ-016 busy_o  output  1: high when the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SEND and GAP; it resets to IDLE.
REQ-018 All outputs SHALL be registered, and a beat is defined as tvalid && tready on a rising edge.
REQ-019 Transition IDLE->SEND SHALL occur on the edge where start_en_i && channel_up is sampled high; tvalid rises in the cycle after that edge.
REQ-020 In SEND, tvalid SHALL be 1, and tdata/tlast SHALL hold stable while tready is 0.
REQ-021 Word index k (16-bit, 0..FRAME_LEN-1) SHALL advance only on a beat.
REQ-022 The data pattern SHALL be: k=0 -> {16'hA55A, seq[15:0]}; k>=1 -> {seq[15:0], k[15:0]}.
REQ-023 seq SHALL be 16 bits, reset to 0, increment on each completed frame, and wrap from 16'hFFFF to 0.
REQ-024 s_axi_tx_tkeep SHALL be all ones whenever tvalid is 1, and 0 otherwise.
REQ-025 tlast SHALL be 1 only while k == FRAME_LEN-1.
REQ-026 On the last beat, the block SHALL increment frame_cnt_o and seq, reset k to 0, and drop tvalid the next cycle when GAP_CYCLES > 0.
REQ-027 frame_cnt_o SHALL wrap modulo 2^32.
REQ-028 GAP SHALL last exactly GAP_CYCLES cycles with tvalid = 0; it then goes to SEND if start_en_i && channel_up, else to IDLE.
REQ-029 When GAP_CYCLES == 0, the last beat SHALL go directly to SEND when start_en_i && channel_up, with the next frame's k=0 word valid in the very next cycle (no bubble); otherwise it goes to IDLE.
REQ-030 If start_en_i falls mid-frame, the current frame SHALL complete normally; no new frame starts.
REQ-031 If channel_up is sampled low in SEND, the block SHALL:
  - abort: tvalid and tlast are 0 from the next cycle;
  - go to IDLE;
  - reset k to 0;
  - leave seq unchanged, so the retry reuses the same seq;
  - increment abort_cnt_o, saturating at 16'hFFFF.
REQ-032 If channel_up falls and a beat occurs on the same edge, the abort SHALL take precedence: that beat is not counted and frame_cnt_o is unchanged, even if it was the last beat.
REQ-033 If channel_up is low in GAP, the block SHALL finish the gap, then go to IDLE.

Reset
REQ-034 While rst_i is high, the following SHALL be held: state = IDLE; tvalid, tlast, tdata and tkeep = 0; k = 0; seq = 0; frame_cnt_o = 0; abort_cnt_o = 0; busy_o = 0.
REQ-035 Reset asserted mid-frame SHALL drop tvalid on the next edge and discard the frame without counting it as an abort.
REQ-036 After rst_i deasserts, the first frame SHALL start no earlier than one cycle after start_en_i && channel_up is sampled high.

Verification
REQ-037 Nominal (FRAME_LEN=4, GAP_CYCLES=2, tready=1, start_en_i and channel_up high) -> words A55A0000, 00000001, 00000002, 00000003 with tlast on the 4th, then 2 idle cycles, then A55A0001; frame_cnt_o = 1 after the first tlast beat.
REQ-038 Backpressure (tready toggled 1,0,0,1 on every word) -> tdata and tlast stable through the stalls; exactly FRAME_LEN beats per frame; the pattern is unchanged.
REQ-039 Back-to-back (GAP_CYCLES=0, tready=1) -> tvalid continuously 1; the word after tlast is A55A0001; seq wraps from FFFF to 0000 after 65536 frames; frame_cnt_o counts continuously.
REQ-040 Abort (channel_up dropped at k=2 of frame seq=5) -> tvalid = 0 next cycle; abort_cnt_o = 1; frame_cnt_o unchanged; after channel_up returns, the first word is A55A0005.
REQ-041 Stop and reset: start_en_i dropped at k=1 -> frame completes through tlast, then IDLE and busy_o = 0; rst_i asserted at k=2 -> all outputs 0 next edge, and abort_cnt_o stays 0.
